// File: rtl/programmable_timer.sv
// Programmable interval timer: period N, prescale P, one-shot or periodic.
// Emits a registered one-clock pulse t on each expiry; done is sticky for one-shot.
module programmable_timer #(
    parameter int WIDTH     = 16,
    parameter int PRE_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [WIDTH-1:0]     load_value,
    input  logic [PRE_WIDTH-1:0] prescale,
    input  logic                 periodic,
    output logic                 t,
    output logic                 running,
    output logic [WIDTH-1:0]     count,
    output logic                 done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic [WIDTH-1:0]     n_r, n_d;
    logic [PRE_WIDTH-1:0] pre_q, pre_d;
    logic [PRE_WIDTH-1:0] p_r, p_d;
    logic                 mode_r, mode_d;
    logic                 t_q, t_d;
    logic                 done_q, done_d;

    // NOTE: non-blocking assignments only in clocked blocks, so every register
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            n_r     <= '0;
            pre_q   <= '0;
            p_r     <= '0;
            mode_r  <= 1'b0;
            t_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            n_r     <= n_d;
            pre_q   <= pre_d;
            p_r     <= p_d;
            mode_r  <= mode_d;
            t_q     <= t_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a hold/default value first,
        // so no path through the branches below can infer a latch.
        state_d = state_q;
        count_d = count_q;
        n_d     = n_r;
        pre_d   = pre_q;
        p_d     = p_r;
        mode_d  = mode_r;
        t_d     = 1'b0;
        done_d  = done_q;

        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            // Arm or restart from the full period; an aborted interval emits no t.
            state_d = RUN;
            count_d = load_value;
            n_d     = load_value;
            p_d     = prescale;
            mode_d  = periodic;
            pre_d   = '0;
            done_d  = 1'b0;
        end else if (state_q == RUN) begin
            if (pre_q == p_r) begin
                pre_d = '0;
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                end else begin
                    t_d = 1'b1;
                    if (mode_r) begin
                        count_d = n_r;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    assign t       = t_q;
    assign running = (state_q == RUN);
    assign count   = count_q;
    assign done    = done_q;

endmodule

// File: tb/tb_programmable_timer.sv
// Directed bench for programmable_timer: hand-computed counts and pulse spacings.
`timescale 1ns/1ps
module tb_programmable_timer;

    localparam int WIDTH     = 16;
    localparam int PRE_WIDTH = 8;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic                 stop  = 1'b0;
    logic [WIDTH-1:0]     load_value = '0;
    logic [PRE_WIDTH-1:0] prescale   = '0;
    logic                 periodic   = 1'b0;
    logic                 t;
    logic                 running;
    logic [WIDTH-1:0]     count;
    logic                 done;

    int total = 0;
    int bad   = 0;
    int n;

    programmable_timer #(.WIDTH(WIDTH), .PRE_WIDTH(PRE_WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .load_value (load_value),
        .prescale   (prescale),
        .periodic   (periodic),
        .t          (t),
        .running    (running),
        .count      (count),
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input int nv, input int pv, input logic per);
        load_value = WIDTH'(nv);
        prescale   = PRE_WIDTH'(pv);
        periodic   = per;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Edges until t is seen; returns limit when it never appears.
    task automatic wait_t(input int limit, output int cycles);
        cycles = 0;
        while (cycles < limit) begin
            tick();
            cycles++;
            if (t) break;
        end
    endtask

    initial begin
        // Reset held 20 ns, then idle with no start for 200 ns.
        #20 reset = 1'b0;
        #1;
        for (int i = 0; i < 20; i++) begin
            check("idle_after_reset", {t, running, done, 16'(count)}, 32'd0);
            #10;
        end
        tick();

        // N=3, P=0 one-shot.
        do_start(3, 0, 1'b0);
        check("os_count0", count, 3);
        check("os_running", running, 1);
        tick(); check("os_count1", count, 2);
        tick(); check("os_count2", count, 1);
        tick(); check("os_count3", count, 0);
        check("os_no_early_t", t, 0);
        tick();
        check("os_t", t, 1);
        check("os_running_off", running, 0);
        check("os_done", done, 1);
        check("os_count_end", count, 0);
        tick();
        check("os_t_one_wide", t, 0);

        // N=2, P=1 periodic: 5 pulses, 6 cycles apart.
        do_start(2, 1, 1'b1);
        check("per_done_cleared", done, 0);
        for (int i = 0; i < 5; i++) begin
            wait_t(20, n);
            check("per_spacing", n, 6);
            check("per_reload", count, 2);
            check("per_running", running, 1);
        end
        stop = 1'b1; tick(); stop = 1'b0;

        // N=0 one-shot with P=2: single pulse after 3 cycles.
        do_start(0, 2, 1'b0);
        wait_t(20, n);
        check("n0_os_delay", n, 3);
        check("n0_os_done", done, 1);
        tick();
        check("n0_os_t_once", t, 0);

        // Stop at edge 3 of N=5 periodic run.
        do_start(5, 0, 1'b1);
        check("stop_done_cleared", done, 0);
        tick(); tick();
        check("stop_pre_count", count, 3);
        stop = 1'b1; tick(); stop = 1'b0;
        check("stop_running", running, 0);
        check("stop_frozen", count, 3);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("stop_hold", {t, 16'(count)}, 32'd3);
        end
        do_start(7, 0, 1'b0);
        check("restart_count", count, 7);
        check("restart_running", running, 1);

        // start and stop together in RUN: stop wins, count holds.
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        check("both_running", running, 0);
        check("both_count", count, 7);

        // Restart mid-run at count=1 (N=4, P=0): no t for the aborted interval.
        do_start(4, 0, 1'b1);
        tick(); tick(); tick();
        check("rs_count1", count, 1);
        do_start(4, 0, 1'b1);
        check("rs_reload", count, 4);
        check("rs_no_t", t, 0);
        wait_t(20, n);
        check("rs_next_t", n, 5);
        stop = 1'b1; tick(); stop = 1'b0;

        // N=0, P=0 periodic: t high every cycle.
        do_start(0, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("n0p0_t_cont", t, 1);
        end
        stop = 1'b1; tick(); stop = 1'b0;
        check("n0p0_stop_t", t, 0);

        // Async reset mid-cycle during N=10, P=3 run.
        do_start(10, 3, 1'b1);
        for (int i = 0; i < 7; i++) tick();
        #2 reset = 1'b1;
        #1;
        check("areset_clear", {t, running, done, 16'(count)}, 32'd0);
        #2 reset = 1'b0;
        tick();
        check("areset_idle", {t, running, done, 16'(count)}, 32'd0);
        do_start(10, 3, 1'b0);
        wait_t(100, n);
        check("areset_full_period", n, 44);
        check("areset_done", done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
